// File: rtl/instruction_fetch.sv
// Instruction fetch unit: walks the program ROM, buffers one decoded word at a time
// for the execute stage behind a valid/ready handshake, and applies branch redirects.
module instruction_fetch #(
  parameter int unsigned ADDR_WIDTH    = 5,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned OPCODE_WIDTH  = 4,
  parameter int unsigned OPERAND_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     fetch_enable,
  output logic [ADDR_WIDTH-1:0]    rom_address,
  output logic                     rom_cs,
  input  logic [DATA_WIDTH-1:0]    rom_data,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [OPCODE_WIDTH-1:0]  instr_opcode,
  output logic [OPERAND_WIDTH-1:0] instr_operand,
  output logic [ADDR_WIDTH-1:0]    instr_pc,
  input  logic                     branch_valid,
  input  logic [ADDR_WIDTH-1:0]    branch_target
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] PcOne = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]               state_q, state_d;
  logic [ADDR_WIDTH-1:0]    pc_q, pc_d;
  logic                     valid_q, valid_d;
  logic [OPCODE_WIDTH-1:0]  opcode_q, opcode_d;
  logic [OPERAND_WIDTH-1:0] operand_q, operand_d;
  logic [ADDR_WIDTH-1:0]    ipc_q, ipc_d;

  // Middle bits of the word carry no meaning for this CPU.
  logic unused_rom_bits;
  assign unused_rom_bits = ^rom_data[DATA_WIDTH-OPCODE_WIDTH-1:OPERAND_WIDTH];

  // Next-state logic: a branch overrides both capture and handshake.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    valid_d   = valid_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    ipc_d     = ipc_q;

    if (branch_valid) begin
      pc_d    = branch_target;
      valid_d = 1'b0;
      state_d = fetch_enable ? FETCH : IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (fetch_enable) state_d = FETCH;
        end
        FETCH: begin
          // Fetch completes even if fetch_enable has dropped.
          opcode_d  = rom_data[DATA_WIDTH-1 -: OPCODE_WIDTH];
          operand_d = rom_data[OPERAND_WIDTH-1:0];
          ipc_d     = pc_q;
          valid_d   = 1'b1;
          pc_d      = pc_q + PcOne;
          state_d   = HOLD;
        end
        HOLD: begin
          if (valid_q && instr_ready) begin
            valid_d = 1'b0;
            state_d = fetch_enable ? FETCH : IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and buffer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      valid_q   <= 1'b0;
      opcode_q  <= '0;
      operand_q <= '0;
      ipc_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      valid_q   <= valid_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      ipc_q     <= ipc_d;
    end
  end

  assign rom_address   = pc_q;
  assign rom_cs        = (state_q == FETCH);
  assign instr_valid   = valid_q;
  assign instr_opcode  = opcode_q;
  assign instr_operand = operand_q;
  assign instr_pc      = ipc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus random traffic, all checked
// each cycle against a transaction-level model of the fetch unit.
module tb_instruction_fetch;

  logic        clk;
  logic        reset_n;
  logic        fetch_enable;
  logic [4:0]  rom_address;
  logic        rom_cs;
  logic [31:0] rom_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  instr_opcode;
  logic [15:0] instr_operand;
  logic [4:0]  instr_pc;
  logic        branch_valid;
  logic [4:0]  branch_target;

  logic [31:0] rom [32];

  int checks = 0;
  int errors = 0;

  // Model: where the PC points, whether a ROM read is underway this cycle,
  // and the word (if any) waiting for execute.
  logic [4:0]  m_pc;
  logic        m_reading;
  logic        m_valid;
  logic [31:0] m_word;
  logic [4:0]  m_wpc;

  instruction_fetch dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .fetch_enable  (fetch_enable),
    .rom_address   (rom_address),
    .rom_cs        (rom_cs),
    .rom_data      (rom_data),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_opcode  (instr_opcode),
    .instr_operand (instr_operand),
    .instr_pc      (instr_pc),
    .branch_valid  (branch_valid),
    .branch_target (branch_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rom_data = rom[rom_address];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = '0; m_reading = 1'b0; m_valid = 1'b0; m_word = '0; m_wpc = '0;
  endtask

  // One clock of the model, applying the rules of the fetch unit.
  task automatic model_edge(input logic fe, input logic rdy, input logic bv,
                            input logic [4:0] bt);
    if (bv) begin
      m_pc = bt; m_valid = 1'b0; m_reading = fe;
    end else if (m_reading) begin
      m_word = rom[m_pc]; m_wpc = m_pc; m_valid = 1'b1;
      m_pc = 5'((int'(m_pc) + 1) % 32);
      m_reading = 1'b0;
    end else if (m_valid) begin
      if (rdy) begin
        m_valid = 1'b0; m_reading = fe;
      end
    end else begin
      m_reading = fe;
    end
  endtask

  task automatic compare();
    check("rom_cs", 32'(rom_cs), 32'(m_reading));
    check("rom_address", 32'(rom_address), 32'(m_pc));
    check("instr_valid", 32'(instr_valid), 32'(m_valid));
    if (m_valid) begin
      check("instr_opcode", 32'(instr_opcode), 32'(m_word[31:28]));
      check("instr_operand", 32'(instr_operand), 32'(m_word[15:0]));
      check("instr_pc", 32'(instr_pc), 32'(m_wpc));
    end
  endtask

  // Called at a negedge: check, drive, advance one clock.
  task automatic step(input logic fe, input logic rdy, input logic bv, input logic [4:0] bt);
    compare();
    fetch_enable = fe; instr_ready = rdy; branch_valid = bv; branch_target = bt;
    @(posedge clk);
    model_edge(fe, rdy, bv, bt);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(instr_valid), 32'd0);
    check({tag, "_cs"}, 32'(rom_cs), 32'd0);
    check({tag, "_addr"}, 32'(rom_address), 32'd0);
    check({tag, "_opcode"}, 32'(instr_opcode), 32'd0);
    check({tag, "_operand"}, 32'(instr_operand), 32'd0);
    check({tag, "_pc"}, 32'(instr_pc), 32'd0);
  endtask

  initial begin
    bit done;
    for (int i = 0; i < 32; i++) rom[i] = (i <= 16'h16) ? $urandom : 32'h0;
    rom[0]     = 32'h4000_000F;
    rom[3]     = 32'h1ABC_0016;
    rom[16'h15] = 32'h8123_0000;

    reset_n = 1'b0; fetch_enable = 1'b0; instr_ready = 1'b0;
    branch_valid = 1'b0; branch_target = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;

    // Scenario 1: first fetch from address 0.
    step(1'b1, 1'b1, 1'b0, 5'd0);
    check("t1_cs", 32'(rom_cs), 32'd1);
    check("t1_addr", 32'(rom_address), 32'd0);
    step(1'b1, 1'b0, 1'b0, 5'd0);
    check("t1_valid", 32'(instr_valid), 32'd1);
    check("t1_opcode", 32'(instr_opcode), 32'd4);
    check("t1_operand", 32'(instr_operand), 32'h000F);
    check("t1_pc", 32'(instr_pc), 32'd0);

    // Scenario 2: stall for five cycles, then release.
    repeat (5) step(1'b1, 1'b0, 1'b0, 5'd0);
    check("t2_held_opcode", 32'(instr_opcode), 32'd4);
    check("t2_pc_not_advanced", 32'(rom_address), 32'd1);
    step(1'b1, 1'b1, 1'b0, 5'd0);
    check("t2_next_fetch_cs", 32'(rom_cs), 32'd1);
    check("t2_next_fetch_addr", 32'(rom_address), 32'd1);

    // Scenario 3: stream through the whole ROM and wrap.
    repeat (70) step(1'b1, 1'b1, 1'b0, 5'd0);

    // Scenario 4: branch while holding the word from 0x10.
    done = 1'b0;
    for (int k = 0; k < 80 && !done; k++) begin
      if (m_valid && m_wpc == 5'h10) done = 1'b1;
      else step(1'b1, !(m_reading && m_pc == 5'h10), 1'b0, 5'd0);
    end
    check("t4_reach_hold", 32'(done), 32'd1);
    check("t4_hold_pc", 32'(instr_pc), 32'h10);
    step(1'b1, 1'b0, 1'b1, 5'd3);
    check("t4_valid_dropped", 32'(instr_valid), 32'd0);
    check("t4_fetch_addr", 32'(rom_address), 32'd3);
    step(1'b1, 1'b0, 1'b0, 5'd0);
    check("t4_pc", 32'(instr_pc), 32'd3);
    check("t4_opcode", 32'(instr_opcode), 32'd1);
    check("t4_operand", 32'(instr_operand), 32'h0016);

    // Scenario 5: branch on the same edge as the fetch of address 5.
    done = 1'b0;
    for (int k = 0; k < 80 && !done; k++) begin
      if (m_reading && m_pc == 5'd5) done = 1'b1;
      else step(1'b1, 1'b1, 1'b0, 5'd0);
    end
    check("t5_reach_fetch5", 32'(done), 32'd1);
    step(1'b1, 1'b1, 1'b1, 5'd9);
    check("t5_no_addr5_word", 32'(instr_valid), 32'd0);
    step(1'b1, 1'b0, 1'b0, 5'd0);
    check("t5_branch_word_pc", 32'(instr_pc), 32'd9);

    // Scenario 6: asynchronous reset between edges while holding.
    step(1'b1, 1'b1, 1'b0, 5'd0);
    step(1'b1, 1'b0, 1'b0, 5'd0);
    step(1'b1, 1'b0, 1'b0, 5'd0);
    check("t6_in_hold", 32'(instr_valid), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    step(1'b1, 1'b1, 1'b0, 5'd0);
    check("t6_restart_addr", 32'(rom_address), 32'd0);

    // Random traffic, including idle periods and branches in every state.
    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(0, 9) != 0), $urandom_range(0, 1) == 1,
           ($urandom_range(0, 11) == 0), 5'($urandom_range(0, 31)));
    end
    compare();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
